priv_1_12_trap_sequencer: RTL
=============================

// Module: priv_1_12_trap_sequencer
// PURPOSE
//  Sequences trap entry and MRET for the v1.12 privilege block. Takes one trap or return request,
//  drains the pipeline, writes mepc/mcause/mtval/mstatus, and redirects the PC. Sits between
//  int_ex_handler (cause source), the CSR file (inject_* port) and pipeline control (insert_pc/priv_pc).
//  Owns the current privilege register.
// PARAMETERS
//  HAS_U_MODE     1   1: MRET to U legal, mstatus.MPP cleared to U on MRET; 0: MPP/priv pinned to M
//  DRAIN_TIMEOUT  64  cycles in DRAIN before drain_timeout flags (counter width $clog2(DRAIN_TIMEOUT+1))
// PORTS
//  CLK            in   1   clock
//  RST            in   1   asynchronous reset, active-high
//  trap_req       in   1   handler has a trap pending; held until trap_ack
//  trap_is_intr   in   1   1=interrupt, 0=exception (sampled with trap_req)
//  trap_cause     in   31  cause code (sampled with trap_req)
//  trap_epc       in   32  pc to save in mepc
//  trap_tval      in   32  value for mtval
//  mret_req       in   1   MRET retiring; held until ret_ack
//  pipe_clear     in   1   pipeline has no in-flight hazards
//  curr_mtvec     in   32  [31:2] base, [1:0] mode (0 direct, 1 vectored, others treated as direct)
//  curr_mepc      in   32  current mepc
//  curr_mstatus   in   32  current mstatus (MIE[3], MPIE[7], MPP[12:11])
//  flush_req      out  1   ask pipeline to stop fetching and drain
//  inject_mepc    out  1   write-enable pulses to CSR file; next_* valid in the same cycle
//  inject_mcause  out  1
//  inject_mtval   out  1
//  inject_mstatus out  1
//  next_mepc      out  32
//  next_mcause    out  32  {trap_is_intr, trap_cause}
//  next_mtval     out  32
//  next_mstatus   out  32
//  insert_pc      out  1   one-cycle pulse: pipeline must load priv_pc
//  priv_pc        out  32  redirect target
//  trap_ack       out  1   one-cycle pulse on trap COMMIT
//  ret_ack        out  1   one-cycle pulse on MRET COMMIT
//  curr_priv      out  2   current privilege (U=2'b00, M=2'b11)
//  busy           out  1   FSM not IDLE
//  drain_timeout  out  1   DRAIN exceeded DRAIN_TIMEOUT; sticky until return to IDLE
// BEHAVIOUR
//  - Reset: FSM IDLE, curr_priv=M, all pulses/flush/busy/drain_timeout 0, next_*/priv_pc 0, counter 0.
//  - States: IDLE, DRAIN, COMMIT, REDIRECT. Latched kind flag: TRAP or RET.
//  - IDLE: trap_req -> DRAIN(TRAP), latch cause/intr/epc/tval; else mret_req -> DRAIN(RET).
//    Both in the same cycle: trap wins, mret_req is not acked.
//  - DRAIN: flush_req=1, counter++ (saturates); pipe_clear -> COMMIT. Counter reaching DRAIN_TIMEOUT
//    sets drain_timeout; FSM keeps waiting (never skips drain).
//  - COMMIT, one cycle, flush_req=1:
//    TRAP: inject all four; next_mepc=epc&~3; next_mtval=tval; MPIE<=MIE, MIE<=0, MPP<=curr_priv;
//      curr_priv<=M on the next edge; trap_ack=1.
//      priv_pc = vectored&&intr ? {base,2'b00}+(cause<<2) (32-bit wrap) : {base,2'b00}.
//    RET: inject_mstatus only; MIE<=MPIE, MPIE<=1, MPP<=U (M if !HAS_U_MODE);
//      curr_priv<=MPP (MPP=S/reserved, or U with !HAS_U_MODE -> M); priv_pc=curr_mepc&~3; ret_ack=1.
//    Other mstatus bits pass through from curr_mstatus.
//  - REDIRECT: insert_pc=1 for exactly one cycle, flush_req=1; -> IDLE. Clears counter and drain_timeout.
//  - Requests arriving while busy are ignored; sources hold them until acked. Trap entry to IDLE takes
//    min 4 cycles (pipe_clear already high).
//  - Reset mid-sequence: immediate abort to reset state; partially issued injects are not retried.
// STRUCTURE
//  - Package priv_1_12_trap_seq_pkg: trap_seq_state_t enum, trap_kind_t, mtvec mode constants,
//    mstatus bit positions, PRIV_U/PRIV_M constants.
//  - Sub-module priv_1_12_trap_target: combinational priv_pc / next_mstatus compute; FSM stays in top.
// TESTING
//  - Direct exception: trap_req, cause=2, epc=0x104, mtvec=0x8000_0000, MIE=1, pipe_clear=1 ->
//    trap_ack in cycle 3, mcause=0x2, mepc=0x104, MPIE=1 MIE=0, insert_pc cycle 4 priv_pc=0x8000_0000.
//  - Vectored interrupt: mtvec=0x8000_0001, intr=1, cause=7 -> priv_pc=0x8000_001C, mcause=0x8000_0007.
//  - Drain stall: pipe_clear low 70 cycles -> flush_req held, drain_timeout set at 64, commit after clear.
//  - MRET from M, MPP=U, MPIE=1 -> ret_ack, MIE=1, MPP=U, curr_priv=U, priv_pc=mepc&~3.
//  - trap_req and mret_req together -> trap taken, no ret_ack; mret_req served after return to IDLE.
//  - RST asserted in COMMIT -> outputs to reset values same cycle, curr_priv=M, no insert_pc.

Source files
------------

// File: rtl/priv_1_12_trap_seq_pkg.sv
// ============================================================================
// Module  : priv_1_12_trap_seq_pkg
// Brief   : Shared types and constants for the trap/MRET sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package priv_1_12_trap_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_seq_state_t;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_RET  = 1'b1
  } trap_kind_t;

  localparam logic [1:0] c_mtvec_mode_direct   = 2'd0;
  localparam logic [1:0] c_mtvec_mode_vectored = 2'd1;

  localparam int c_mstatus_mie    = 3;
  localparam int c_mstatus_mpie   = 7;
  localparam int c_mstatus_mpp_lo = 11;
  localparam int c_mstatus_mpp_hi = 12;

  localparam logic [1:0] c_priv_u = 2'b00;
  localparam logic [1:0] c_priv_m = 2'b11;

endpackage

`default_nettype wire

// File: rtl/priv_1_12_trap_seq_if.sv
// ============================================================================
// Module  : priv_1_12_trap_seq_if
// Brief   : Request, CSR-inject and pipeline-redirect bundle of the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface priv_1_12_trap_seq_if;

  logic        trap_req;
  logic        trap_is_intr;
  logic [30:0] trap_cause;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic        mret_req;
  logic        pipe_clear;
  logic [31:0] curr_mtvec;
  logic [31:0] curr_mepc;
  logic [31:0] curr_mstatus;

  logic        flush_req;
  logic        inject_mepc;
  logic        inject_mcause;
  logic        inject_mtval;
  logic        inject_mstatus;
  logic [31:0] next_mepc;
  logic [31:0] next_mcause;
  logic [31:0] next_mtval;
  logic [31:0] next_mstatus;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        trap_ack;
  logic        ret_ack;
  logic [1:0]  curr_priv;
  logic        busy;
  logic        drain_timeout;

  modport master (
    output trap_req, trap_is_intr, trap_cause, trap_epc, trap_tval, mret_req,
           pipe_clear, curr_mtvec, curr_mepc, curr_mstatus,
    input  flush_req, inject_mepc, inject_mcause, inject_mtval, inject_mstatus,
           next_mepc, next_mcause, next_mtval, next_mstatus, insert_pc, priv_pc,
           trap_ack, ret_ack, curr_priv, busy, drain_timeout
  );

  modport slave (
    input  trap_req, trap_is_intr, trap_cause, trap_epc, trap_tval, mret_req,
           pipe_clear, curr_mtvec, curr_mepc, curr_mstatus,
    output flush_req, inject_mepc, inject_mcause, inject_mtval, inject_mstatus,
           next_mepc, next_mcause, next_mtval, next_mstatus, insert_pc, priv_pc,
           trap_ack, ret_ack, curr_priv, busy, drain_timeout
  );

endinterface

`default_nettype wire

// File: rtl/priv_1_12_trap_target.sv
// ============================================================================
// Module  : priv_1_12_trap_target
// Brief   : Combinational redirect target, new mstatus and new privilege.
// Revision: 1.0
// ============================================================================
`default_nettype none

module priv_1_12_trap_target
  import priv_1_12_trap_seq_pkg::*;
#(
  parameter int HAS_U_MODE = 1
) (
  input  trap_kind_t  i_kind,
  input  logic        i_intr,
  input  logic [29:0] i_cause_lo,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic [31:0] i_mstatus,
  input  logic [1:0]  i_priv,
  output logic [31:0] o_priv_pc,
  output logic [31:0] o_next_mstatus,
  output logic [1:0]  o_next_priv
);

  logic [31:0] w_base;
  logic [1:0]  w_mpp;

  assign w_base = i_mtvec & ~32'h3;
  assign w_mpp  = i_mstatus[c_mstatus_mpp_hi:c_mstatus_mpp_lo];

  always_comb begin
    o_next_mstatus = i_mstatus;
    o_priv_pc      = w_base;
    o_next_priv    = c_priv_m;
    if (i_kind == KIND_TRAP) begin
      o_next_mstatus[c_mstatus_mpie] = i_mstatus[c_mstatus_mie];
      o_next_mstatus[c_mstatus_mie]  = 1'b0;
      o_next_mstatus[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = i_priv;
      // Only interrupts are vectored; the cause offset wraps at 32 bits.
      if ((i_mtvec[1:0] == c_mtvec_mode_vectored) && i_intr) begin
        o_priv_pc = w_base + {i_cause_lo, 2'b00};
      end
    end else begin
      o_next_mstatus[c_mstatus_mie]  = i_mstatus[c_mstatus_mpie];
      o_next_mstatus[c_mstatus_mpie] = 1'b1;
      o_next_mstatus[c_mstatus_mpp_hi:c_mstatus_mpp_lo] =
        (HAS_U_MODE != 0) ? c_priv_u : c_priv_m;
      // S and reserved encodings fall back to M.
      o_next_priv = ((w_mpp == c_priv_u) && (HAS_U_MODE != 0)) ? c_priv_u : c_priv_m;
      o_priv_pc   = i_mepc & ~32'h3;
    end
  end

endmodule

`default_nettype wire

// File: rtl/priv_1_12_trap_sequencer.sv
// ============================================================================
// Module  : priv_1_12_trap_sequencer
// Brief   : Drains the pipeline, commits trap/MRET CSR state, redirects the PC.
// Revision: 1.0
// ============================================================================
`default_nettype none

module priv_1_12_trap_sequencer
  import priv_1_12_trap_seq_pkg::*;
#(
  parameter int HAS_U_MODE    = 1,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  priv_1_12_trap_seq_if.slave        bus
);

  localparam int                  c_cnt_w     = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_limit = c_cnt_w'(DRAIN_TIMEOUT);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);

  trap_seq_state_t    r_state;
  trap_kind_t         r_kind;
  logic               r_intr;
  logic [30:0]        r_cause;
  logic [31:0]        r_epc;
  logic [31:0]        r_tval;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_timeout;
  logic               r_busy;
  logic               r_trap_ack;
  logic               r_ret_ack;
  logic               r_inj_mepc;
  logic               r_inj_mcause;
  logic               r_inj_mtval;
  logic               r_inj_mstatus;
  logic [31:0]        r_next_mepc;
  logic [31:0]        r_next_mcause;
  logic [31:0]        r_next_mtval;
  logic [31:0]        r_next_mstatus;
  logic               r_insert_pc;
  logic [31:0]        r_priv_pc;
  logic [1:0]         r_priv;
  logic [1:0]         r_new_priv;

  logic [31:0]        w_priv_pc;
  logic [31:0]        w_next_mstatus;
  logic [1:0]         w_next_priv;

  priv_1_12_trap_target #(
    .HAS_U_MODE (HAS_U_MODE)
  ) u_target (
    .i_kind         (r_kind),
    .i_intr         (r_intr),
    .i_cause_lo     (r_cause[29:0]),
    .i_mtvec        (bus.curr_mtvec),
    .i_mepc         (bus.curr_mepc),
    .i_mstatus      (bus.curr_mstatus),
    .i_priv         (r_priv),
    .o_priv_pc      (w_priv_pc),
    .o_next_mstatus (w_next_mstatus),
    .o_next_priv    (w_next_priv)
  );

  // Outputs of a state are loaded on the edge that enters it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_kind         <= KIND_TRAP;
      r_intr         <= 1'b0;
      r_cause        <= '0;
      r_epc          <= '0;
      r_tval         <= '0;
      r_cnt          <= '0;
      r_timeout      <= 1'b0;
      r_busy         <= 1'b0;
      r_trap_ack     <= 1'b0;
      r_ret_ack      <= 1'b0;
      r_inj_mepc     <= 1'b0;
      r_inj_mcause   <= 1'b0;
      r_inj_mtval    <= 1'b0;
      r_inj_mstatus  <= 1'b0;
      r_next_mepc    <= '0;
      r_next_mcause  <= '0;
      r_next_mtval   <= '0;
      r_next_mstatus <= '0;
      r_insert_pc    <= 1'b0;
      r_priv_pc      <= '0;
      r_priv         <= c_priv_m;
      r_new_priv     <= c_priv_m;
    end else begin
      r_trap_ack    <= 1'b0;
      r_ret_ack     <= 1'b0;
      r_inj_mepc    <= 1'b0;
      r_inj_mcause  <= 1'b0;
      r_inj_mtval   <= 1'b0;
      r_inj_mstatus <= 1'b0;
      r_insert_pc   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.trap_req) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
            r_kind  <= KIND_TRAP;
            r_intr  <= bus.trap_is_intr;
            r_cause <= bus.trap_cause;
            r_epc   <= bus.trap_epc;
            r_tval  <= bus.trap_tval;
          end else if (bus.mret_req) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
            r_kind  <= KIND_RET;
          end
        end
        ST_DRAIN: begin
          if (r_cnt != c_cnt_limit) begin
            r_cnt <= r_cnt + c_cnt_one;
          end
          if (r_cnt >= c_cnt_limit - c_cnt_one) begin
            r_timeout <= 1'b1;
          end
          if (bus.pipe_clear) begin
            r_state        <= ST_COMMIT;
            r_inj_mstatus  <= 1'b1;
            r_next_mstatus <= w_next_mstatus;
            r_priv_pc      <= w_priv_pc;
            r_new_priv     <= w_next_priv;
            if (r_kind == KIND_TRAP) begin
              r_inj_mepc    <= 1'b1;
              r_inj_mcause  <= 1'b1;
              r_inj_mtval   <= 1'b1;
              r_next_mepc   <= r_epc & ~32'h3;
              r_next_mcause <= {r_intr, r_cause};
              r_next_mtval  <= r_tval;
              r_trap_ack    <= 1'b1;
            end else begin
              r_ret_ack     <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_state     <= ST_REDIRECT;
          r_priv      <= r_new_priv;
          r_insert_pc <= 1'b1;
        end
        ST_REDIRECT: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flush_req      = r_busy;
  assign bus.busy           = r_busy;
  assign bus.inject_mepc    = r_inj_mepc;
  assign bus.inject_mcause  = r_inj_mcause;
  assign bus.inject_mtval   = r_inj_mtval;
  assign bus.inject_mstatus = r_inj_mstatus;
  assign bus.next_mepc      = r_next_mepc;
  assign bus.next_mcause    = r_next_mcause;
  assign bus.next_mtval     = r_next_mtval;
  assign bus.next_mstatus   = r_next_mstatus;
  assign bus.insert_pc      = r_insert_pc;
  assign bus.priv_pc        = r_priv_pc;
  assign bus.trap_ack       = r_trap_ack;
  assign bus.ret_ack        = r_ret_ack;
  assign bus.curr_priv      = r_priv;
  assign bus.drain_timeout  = r_timeout;

endmodule

`default_nettype wire
